// File: rtl/snake_head_ctrl.sv
// rtl/snake_head_ctrl.sv - snake head controller: direction buffering, move ticks, collisions, food score
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   sys        move tick, single-cycle strobe
//   restart    synchronous restart, same values as reset
//   L/U/D/R    direction request levels (priority U > D > L > R)
//   RedPixels  food map, bit i*COLS+j = cell (i,j)
//   GrnPixels  body map, same layout
//   i_head     head row
//   j_head     head column
//   dir        committed direction (0=L 1=U 2=D 3=R)
//   eaten      one-cycle pulse when the head enters a food cell
//   gameOver   high while in OVER
//   score      saturating food count
module snake_head_ctrl #(
    parameter int           ROWS      = 16,
    parameter int           COLS      = 16,
    parameter int           CW        = 5,
    parameter int           WRAP      = 0,
    parameter int           START_I   = 10,
    parameter int           START_J   = 7,
    parameter logic [1:0]   START_DIR = 2'd0,
    parameter int           SCORE_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sys,
    input  logic                 restart,
    input  logic                 L,
    input  logic                 U,
    input  logic                 D,
    input  logic                 R,
    input  logic [ROWS*COLS-1:0] RedPixels,
    input  logic [ROWS*COLS-1:0] GrnPixels,
    output logic [CW-1:0]        i_head,
    output logic [CW-1:0]        j_head,
    output logic [1:0]           dir,
    output logic                 eaten,
    output logic                 gameOver,
    output logic [SCORE_W-1:0]   score
);

    localparam logic [1:0] DIR_L = 2'd0;
    localparam logic [1:0] DIR_U = 2'd1;
    localparam logic [1:0] DIR_D = 2'd2;
    localparam logic [1:0] DIR_R = 2'd3;

    localparam int NPIX = ROWS * COLS;
    localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [CW-1:0]      I_MAX   = CW'(ROWS - 1);
    localparam logic [CW-1:0]      J_MAX   = CW'(COLS - 1);
    localparam logic [CW-1:0]      I_START = CW'(START_I);
    localparam logic [CW-1:0]      J_START = CW'(START_J);
    localparam logic [SCORE_W-1:0] SCORE_SAT = '1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_OVER = 1'b1
    } state_t;

    state_t             r_state, w_state_n;
    logic [1:0]         r_dir, w_dir_n;
    logic [1:0]         r_pend, w_pend_n;
    logic [CW-1:0]      r_i, w_i_n;
    logic [CW-1:0]      r_j, w_j_n;
    logic               r_eaten, w_eaten_n;
    logic [SCORE_W-1:0] r_score, w_score_n;

    logic               w_req_valid;
    logic [1:0]         w_req_dir;
    logic [1:0]         w_cmp_dir;
    logic               w_press_ok;
    logic [CW-1:0]      w_ni, w_nj;
    logic               w_oob;
    logic [IW-1:0]      w_idx;
    logic               w_body, w_food;

    // Request arbitration: U > D > L > R.
    always_comb begin
        w_req_valid = U | D | L | R;
        if (U)      w_req_dir = DIR_U;
        else if (D) w_req_dir = DIR_D;
        else if (L) w_req_dir = DIR_L;
        else        w_req_dir = DIR_R;
    end

    // On a tick cycle the press must be judged against the direction being
    // committed right now (old pend), not the one about to be replaced.
    // The encoding makes the reverse of any direction its bitwise complement.
    always_comb begin
        w_cmp_dir  = sys ? r_pend : r_dir;
        w_press_ok = w_req_valid && (w_req_dir != ~w_cmp_dir);
    end

    // Next head cell from the pending direction. Columns run reversed on the
    // matrix, so L increments j and R decrements it.
    always_comb begin
        w_ni  = r_i;
        w_nj  = r_j;
        w_oob = 1'b0;
        case (r_pend)
            DIR_L: begin
                if (r_j == J_MAX) begin
                    if (WRAP != 0) w_nj = '0;
                    else           w_oob = 1'b1;
                end else begin
                    w_nj = r_j + CW'(1);
                end
            end
            DIR_R: begin
                if (r_j == '0) begin
                    if (WRAP != 0) w_nj = J_MAX;
                    else           w_oob = 1'b1;
                end else begin
                    w_nj = r_j - CW'(1);
                end
            end
            DIR_U: begin
                if (r_i == '0) begin
                    if (WRAP != 0) w_ni = I_MAX;
                    else           w_oob = 1'b1;
                end else begin
                    w_ni = r_i - CW'(1);
                end
            end
            default: begin
                if (r_i == I_MAX) begin
                    if (WRAP != 0) w_ni = '0;
                    else           w_oob = 1'b1;
                end else begin
                    w_ni = r_i + CW'(1);
                end
            end
        endcase
    end

    // When out of range the cell falls back to the current head, which keeps
    // the index inside the maps; w_oob already decides the outcome then.
    always_comb begin
        w_idx  = IW'(w_ni) * IW'(COLS) + IW'(w_nj);
        w_body = GrnPixels[w_idx];
        w_food = RedPixels[w_idx];
    end

    // Next-state and output logic.
    always_comb begin
        w_state_n = r_state;
        w_dir_n   = r_dir;
        w_pend_n  = r_pend;
        w_i_n     = r_i;
        w_j_n     = r_j;
        w_eaten_n = 1'b0;
        w_score_n = r_score;

        if (restart) begin
            w_state_n = ST_RUN;
            w_dir_n   = START_DIR;
            w_pend_n  = START_DIR;
            w_i_n     = I_START;
            w_j_n     = J_START;
            w_score_n = '0;
        end else if (r_state == ST_RUN) begin
            if (sys) begin
                w_dir_n = r_pend;
                if (w_oob || w_body) begin
                    w_state_n = ST_OVER;
                end else begin
                    w_i_n = w_ni;
                    w_j_n = w_nj;
                    if (w_food) begin
                        w_eaten_n = 1'b1;
                        if (r_score != SCORE_SAT) w_score_n = r_score + SCORE_W'(1);
                    end
                end
            end
            if (w_press_ok) w_pend_n = w_req_dir;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_dir   <= START_DIR;
            r_pend  <= START_DIR;
            r_i     <= I_START;
            r_j     <= J_START;
            r_eaten <= 1'b0;
            r_score <= '0;
        end else begin
            r_state <= w_state_n;
            r_dir   <= w_dir_n;
            r_pend  <= w_pend_n;
            r_i     <= w_i_n;
            r_j     <= w_j_n;
            r_eaten <= w_eaten_n;
            r_score <= w_score_n;
        end
    end

    assign i_head   = r_i;
    assign j_head   = r_j;
    assign dir      = r_dir;
    assign eaten    = r_eaten;
    assign gameOver = (r_state == ST_OVER);
    assign score    = r_score;

endmodule

// File: doc/snake_head_ctrl.md
# snake_head_ctrl

Parametrised snake-head controller for the LED-matrix snake game. It buffers player direction presses between move ticks and rejects 180° reversals. On each move tick it advances the head one cell and detects wall or body collisions, with walls either fatal or wrapping per a mode parameter. It also emits a one-cycle eaten pulse with a saturating score. It sits between the button/debounce logic and the body/food/display blocks, replacing the fixed 16x16 head FSM.

## Interface

Parameters:
- ROWS, 16: grid rows; i coordinate range 0..ROWS-1
- COLS, 16: grid columns; j coordinate range 0..COLS-1
- CW, 5: coordinate width; must satisfy 2**CW > max(ROWS, COLS)
- WRAP, 0: 0 = leaving the grid is fatal; 1 = head wraps to the opposite edge
- START_I, 10: reset row
- START_J, 7: reset column
- START_DIR, 2'd0: reset direction; 0 = L, 1 = U, 2 = D, 3 = R
- SCORE_W, 8: score counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sys  in  1  move tick, one clk-cycle strobe
- restart  in  1  synchronous restart; same effect as reset
- L, U, D, R  in  1 each  direction requests, level, sampled every cycle
- RedPixels  in  ROWS*COLS  food map; bit i*COLS+j = cell (i,j)
- GrnPixels  in  ROWS*COLS  body map, same layout
- i_head  out  CW  head row
- j_head  out  CW  head column
- dir  out  2  committed direction
- eaten  out  1  one-cycle pulse: head entered a food cell
- gameOver  out  1  level, high in OVER
- score  out  SCORE_W  food count, saturating

## Operation

- Movement follows the matrix's reversed column order:
  - L: j+1
  - R: j−1
  - U: i−1
  - D: i+1
- States:
  - RUN: holds committed `dir` and a `pend` direction register.
  - OVER: absorbing; left only via reset or restart.
- Direction buffering, every cycle in RUN:
  - If several requests are asserted, priority is U > D > L > R.
  - The winning request loads `pend` unless it is the reverse of `dir`. Reversals are dropped silently.
  - A later accepted press before the tick overwrites an earlier one.
- Move tick (sys=1 in RUN):
  - `dir` <= `pend`.
  - Compute next cell (ni, nj) from `pend`.
  - Boundary handling:
    - WRAP=0 with next cell out of range (underflow at 0 or index ≥ ROWS/COLS): go to OVER; head holds.
    - WRAP=1: 0−1 becomes ROWS−1 / COLS−1; ROWS / COLS becomes 0.
  - If GrnPixels[ni*COLS+nj] = 1: go to OVER; head holds.
  - Otherwise the head moves to (ni, nj).
  - If RedPixels at the new cell = 1: eaten pulses and score increments, saturating at 2**SCORE_W−1.
- Press on the same cycle as a tick:
  - The tick uses the old `pend`.
  - The press is validated against the newly committed `dir` and loads `pend` for the next tick.
- Ticks and presses are ignored in OVER. eaten never asserts in OVER.
- Red held at the head cell without a new tick produces no further pulses.
- Priority: reset > restart > sys > direction press.

## Timing

- All outputs are registered.
- Reset/restart values:
  - i_head = START_I, j_head = START_J
  - dir = `pend` = START_DIR
  - eaten = 0, gameOver = 0, score = 0
- On a tick at edge N:
  - New i_head, j_head, dir, eaten, score and gameOver are visible after edge N+1.
  - Latency is 1 cycle.
- eaten is high for exactly one cycle per food entry.
- Back-to-back ticks on consecutive cycles are legal; each moves one cell.
- Reset asserted mid-game takes effect immediately, asynchronously; release is synchronised by the instantiating top.
- Collision checks use GrnPixels/RedPixels as presented on the tick cycle.

## Test plan

1. Reset, then 3 ticks with no presses: head (10,7) → (10,8), (10,9), (10,10); gameOver = 0, dir = 0.
2. Reversal rejection, heading L: hold R, tick → head (10,8), dir stays L. Press U, tick → (9,8), dir = U. U and R pressed together → U wins.
3. WRAP=0, START_J=14, heading L: tick → j = 15; tick → gameOver = 1, head stays (10,15). Further ticks and presses change nothing.
4. WRAP=1, same start: ticks → j = 15, then 0; gameOver = 0. Heading U from i = 0 → i = 15.
5. Body collision: GrnPixels bit (10,8) set, heading L from (10,7): tick → gameOver = 1, head stays (10,7), eaten = 0.
6. Food and restart:
   - RedPixels bit (10,8) set: tick → head (10,8), eaten high for exactly 1 cycle, score = 1.
   - Red held with no tick → no second pulse.
   - restart → head (10,7), score = 0, gameOver = 0.
